// File: rtl/hidden_program_sequencer.sv
// hidden_program_sequencer
// Program store and fetch controller for the 4-register HiddenCPU core.
// A host loads 6-bit instructions into an internal buffer while idle. A run
// command resets the core for one cycle, then feeds it instructions fetched at
// its own pc, one per issued step, until the pc leaves the program or the step
// budget is used up.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   load_valid/data  host instruction offer {opcode, addrA, addrB}
//   load_ready       buffer accepts load_data this cycle (IDLE and not full)
//   load_clear       empty the buffer and clear err_overflow
//   run              start execution (IDLE with a program, or HALT)
//   step_mode        1 = issue only on step_req
//   step_req         single-step request
//   max_steps        step budget, 0 = unlimited
//   core_pc          core's current pc
//   core_instr       instruction presented to the core (0 outside RUN)
//   core_issue       core clock-enable
//   core_rst         core reset
//   busy / halted    state is CORE_RST or RUN / state is HALT
//   prog_len         number of instructions loaded
//   steps            instructions issued since the last run
//   err_overflow     sticky: load attempted while the buffer was full
//
// state    | meaning
// IDLE     | host may load or clear the buffer; run starts execution
// CORE_RST | single cycle holding the core in reset
// RUN      | fetch at core_pc and issue steps
// HALT     | execution stopped; run re-executes, load_clear returns to IDLE

module hidden_program_sequencer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [5:0]        load_data,
  output logic              load_ready,
  input  logic              load_clear,
  input  logic              run,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic [STEP_W-1:0] max_steps,
  input  logic [7:0]        core_pc,
  output logic [5:0]        core_instr,
  output logic              core_issue,
  output logic              core_rst,
  output logic              busy,
  output logic              halted,
  output logic [AW:0]       prog_len,
  output logic [STEP_W-1:0] steps,
  output logic              err_overflow
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_RST = 2'd1,
    RUN      = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [AW:0]       prog_len_q, prog_len_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic [5:0]        mem_q [DEPTH];

  logic pc_out;
  logic budget_done;

  // Full-width compare so a pc beyond the buffer index range still halts.
  assign pc_out      = ({24'd0, core_pc} >= 32'(prog_len_q));
  assign budget_done = (max_steps != '0) && (steps_q == max_steps);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prog_len_q <= '0;
      steps_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_len_q <= prog_len_d;
      steps_q    <= steps_d;
      err_q      <= err_d;
    end
  end

  // Buffer contents are not reset; prog_len=0 makes them unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[prog_len_q[AW-1:0]] <= load_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    steps_d    = steps_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    load_ready = 1'b0;
    core_issue = 1'b0;
    core_instr = '0;

    unique case (state_q)
      IDLE: begin
        load_ready = (prog_len_q < (AW+1)'(DEPTH));
        if (load_clear) begin
          // Clear wins over a same-cycle load or run.
          prog_len_d = '0;
          err_d      = 1'b0;
        end else if (load_valid) begin
          if (load_ready) begin
            wr_en      = 1'b1;
            prog_len_d = prog_len_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (run && (prog_len_q != '0)) begin
          state_d = CORE_RST;
          steps_d = '0;
        end
      end

      CORE_RST: begin
        state_d = RUN;
      end

      RUN: begin
        core_instr = mem_q[core_pc[AW-1:0]];
        if (pc_out || budget_done) begin
          state_d = HALT;
        end else begin
          // Gated by rst so the core never sees an issue while in reset.
          core_issue = (!step_mode || step_req) && !rst;
          if (core_issue && (steps_q != '1)) begin
            steps_d = steps_q + 1'b1;
          end
        end
      end

      HALT: begin
        if (run) begin
          state_d = CORE_RST;
          steps_d = '0;
        end else if (load_clear) begin
          state_d    = IDLE;
          prog_len_d = '0;
          err_d      = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign core_rst     = rst || (state_q == CORE_RST);
  assign busy         = (state_q == CORE_RST) || (state_q == RUN);
  assign halted       = (state_q == HALT);
  assign prog_len     = prog_len_q;
  assign steps        = steps_q;
  assign err_overflow = err_q;

endmodule
